// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer queue.
package spi_pkg;

    // Default word width, FIFO depth and completion timeout
    localparam int DefBits    = 8;
    localparam int DefDepth   = 4;
    localparam int DefTimeout = 64;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StStore
    } state_e;

    // Width of the timeout counter; never narrower than one bit
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/spi_xfer_queue_if.sv
// Producer/consumer streams plus the SPI master control bus of the queue.
interface spi_xfer_queue_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [BITS-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic            spi_start;
    logic [BITS-1:0] spi_tx;
    logic [BITS-1:0] spi_rx;
    logic            spi_done;

    // Queue side
    modport slave (
        input  tx_data, tx_valid, rx_ready, spi_rx, spi_done,
        output tx_ready, rx_data, rx_valid, spi_start, spi_tx
    );

    // Producer, consumer and SPI master side
    modport master (
        output tx_data, tx_valid, rx_ready, spi_rx, spi_done,
        input  tx_ready, rx_data, rx_valid, spi_start, spi_tx
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Registered synchronous FIFO, no fall-through. Extra pointer MSB tells full from empty.
module spi_sync_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] wdata,
    input  logic            wvalid,
    output logic            wready,
    output logic [BITS-1:0] rdata,
    output logic            rvalid,
    input  logic            rready
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     wptr_q, rptr_q;
    logic [BITS-1:0] mem_q [DEPTH];
    logic            empty, full, push, pop;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop    = rready && !empty;
    // A write into a full FIFO is taken only when the head leaves in the same cycle;
    // wready itself reports occupancy alone.
    assign push   = wvalid && (!full || pop);
    assign wready = !full;
    assign rvalid = !empty;
    assign rdata  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_xfer_queue.sv
// Queues words for the SPI master, one start pulse per word, and collects replies.
module spi_xfer_queue
    import spi_pkg::*;
#(
    parameter int BITS    = DefBits,
    parameter int DEPTH   = DefDepth,
    parameter int TIMEOUT = DefTimeout
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_xfer_queue_if.slave  bus,
    output logic             busy,
    output logic             timeout_err
);
    localparam int CW = cnt_width(TIMEOUT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] spi_tx_q, spi_tx_d;
    logic [BITS-1:0] cap_q, cap_d;
    logic            err_q, err_d;

    logic [BITS-1:0] tx_head;
    logic            tx_nonempty, tx_pop;
    logic            rx_not_full, rx_push;
    logic            tx_accept, rx_popping;

    assign tx_accept  = bus.tx_valid && bus.tx_ready;
    assign rx_popping = bus.rx_valid && bus.rx_ready;

    spi_sync_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wdata  (bus.tx_data),
        .wvalid (tx_accept),
        .wready (bus.tx_ready),
        .rdata  (tx_head),
        .rvalid (tx_nonempty),
        .rready (tx_pop)
    );

    spi_sync_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wdata  (cap_q),
        .wvalid (rx_push),
        .wready (rx_not_full),
        .rdata  (bus.rx_data),
        .rvalid (bus.rx_valid),
        .rready (bus.rx_ready)
    );

    assign bus.spi_tx  = spi_tx_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != StIdle) || tx_nonempty;

    // Sequencer state, timeout counter, held TX word, captured RX word, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            spi_tx_q <= '0;
            cap_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            spi_tx_q <= spi_tx_d;
            cap_q    <= cap_d;
            err_q    <= err_d;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        spi_tx_d      = spi_tx_q;
        cap_d         = cap_q;
        err_d         = err_q;
        tx_pop        = 1'b0;
        rx_push       = 1'b0;
        bus.spi_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_nonempty) begin
                    tx_pop   = 1'b1;
                    spi_tx_d = tx_head;
                    state_d  = StStart;
                end
            end
            StStart: begin
                bus.spi_start = 1'b1;
                cnt_d         = '0;
                state_d       = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                // done wins over a timeout in the same cycle
                if (bus.spi_done) begin
                    cap_d   = bus.spi_rx;
                    state_d = StStore;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StStore: begin
                // Hold the captured word until the RX FIFO can take it
                if (rx_not_full || rx_popping) begin
                    rx_push = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue with a behavioural SPI master/slave responder.
module tb_spi_xfer_queue;
    localparam int BITS    = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, timeout_err;

    spi_xfer_queue_if #(.BITS(BITS)) q_if ();

    spi_xfer_queue #(.BITS(BITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (q_if.slave),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] starts_q [$];
    logic [7:0] rx_got   [$];
    logic [7:0] slave_word;
    logic [7:0] m_word;
    int         resp_lat;
    bit         resp_en;
    bit         saw_not_ready;
    int         cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input logic [7:0] q [$], input int k);
        return (k < q.size()) ? q[k] : 8'hxx;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_tx_ready"},    q_if.tx_ready,  1'b1);
        check_eq({pfx, "_rx_valid"},    q_if.rx_valid,  1'b0);
        check_eq({pfx, "_rx_data"},     q_if.rx_data,   8'h00);
        check_eq({pfx, "_spi_start"},   q_if.spi_start, 1'b0);
        check_eq({pfx, "_spi_tx"},      q_if.spi_tx,    8'h00);
        check_eq({pfx, "_busy"},        busy,           1'b0);
        check_eq({pfx, "_timeout_err"}, timeout_err,    1'b0);
    endtask

    // Call just after a rising edge; returns just after the accepting edge
    task automatic push_word(input logic [7:0] w);
        int i;
        i = 0;
        q_if.tx_data  = w;
        q_if.tx_valid = 1'b1;
        @(negedge clk);
        while (!q_if.tx_ready && i < 300) begin
            saw_not_ready = 1'b1;
            i++;
            @(negedge clk);
        end
        if (i >= 300) check_eq("push_accept", q_if.tx_ready, 1'b1);
        @(posedge clk);
        #1;
        q_if.tx_valid = 1'b0;
    endtask

    // SPI master plus shift-register slave: replies with its previous contents
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && q_if.spi_start) begin
                m_word = q_if.spi_tx;
                starts_q.push_back(m_word);
                if (resp_en) begin
                    repeat (resp_lat) @(posedge clk);
                    #1;
                    check_eq("spi_tx_held", q_if.spi_tx, m_word);
                    q_if.spi_rx   = slave_word;
                    q_if.spi_done = 1'b1;
                    slave_word    = m_word;
                    @(posedge clk);
                    #1;
                    q_if.spi_done = 1'b0;
                end
            end
        end
    end

    // Consumer: records each word popped on the following edge
    initial begin
        forever begin
            @(negedge clk);
            if (q_if.rx_valid && q_if.rx_ready) rx_got.push_back(q_if.rx_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        q_if.tx_data  = '0;
        q_if.tx_valid = 1'b0;
        q_if.rx_ready = 1'b0;
        q_if.spi_rx   = '0;
        q_if.spi_done = 1'b0;
        rst_n         = 1'b0;
        resp_en       = 1'b1;
        resp_lat      = 5;
        slave_word    = 8'hA5;
        saw_not_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");

        // Single word: start two cycles after the accepting edge
        @(posedge clk); #1;
        push_word(8'h3C);
        @(negedge clk);
        check_eq("lat_idle_no_start", q_if.spi_start, 1'b0);
        @(negedge clk);
        check_eq("lat_start", q_if.spi_start, 1'b1);
        for (int i = 0; i < 100 && !q_if.rx_valid; i++) @(negedge clk);
        check_eq("single_rx_valid", q_if.rx_valid, 1'b1);
        check_eq("single_rx_data", q_if.rx_data, 8'hA5);
        check_eq("single_busy_idle", busy, 1'b0);
        check_eq("single_n_starts", starts_q.size(), 1);
        check_eq("single_start_word", q_at(starts_q, 0), 8'h3C);
        @(posedge clk); #1 q_if.rx_ready = 1'b1;
        @(posedge clk); #1 q_if.rx_ready = 1'b0;
        check_eq("single_popped", q_if.rx_valid, 1'b0);

        // Burst of four with a ready consumer
        starts_q.delete();
        rx_got.delete();
        saw_not_ready = 1'b0;
        q_if.rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_word(8'(k + 1));
        check_eq("burst_tx_ready_held", saw_not_ready, 1'b0);
        for (int i = 0; i < 400 && (rx_got.size() < 4 || busy); i++) @(negedge clk);
        check_eq("burst_n_starts", starts_q.size(), 4);
        check_eq("burst_n_rx", rx_got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("burst_start_%0d", k), q_at(starts_q, k), 8'(k + 1));
            check_eq($sformatf("burst_rx_%0d", k), q_at(rx_got, k),
                     (k == 0) ? 8'h3C : 8'(k));
        end

        // Backpressure: consumer stalled, six words offered
        @(posedge clk); #1;
        starts_q.delete();
        rx_got.delete();
        saw_not_ready = 1'b0;
        q_if.rx_ready = 1'b0;
        for (int k = 0; k < 6; k++) push_word(8'h11 + 8'(k));
        check_eq("bp_tx_ready_dropped", saw_not_ready, 1'b1);
        repeat (150) @(negedge clk);
        check_eq("bp_stall_n_starts", starts_q.size(), 5);
        check_eq("bp_stall_rx_valid", q_if.rx_valid, 1'b1);
        check_eq("bp_stall_busy", busy, 1'b1);
        check_eq("bp_stall_tx_ready", q_if.tx_ready, 1'b1);
        @(posedge clk); #1 q_if.rx_ready = 1'b1;
        for (int i = 0; i < 400 && (rx_got.size() < 6 || busy); i++) @(negedge clk);
        check_eq("bp_n_starts", starts_q.size(), 6);
        check_eq("bp_n_rx", rx_got.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("bp_start_%0d", k), q_at(starts_q, k), 8'h11 + 8'(k));
            check_eq($sformatf("bp_rx_%0d", k), q_at(rx_got, k),
                     (k == 0) ? 8'h04 : 8'h10 + 8'(k));
        end

        // Timeout: no done from the master
        @(posedge clk); #1;
        starts_q.delete();
        rx_got.delete();
        resp_en = 1'b0;
        push_word(8'h55);
        for (int i = 0; i < 50 && !q_if.spi_start; i++) @(negedge clk);
        check_eq("to_start_seen", q_if.spi_start, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!timeout_err && cyc < 200);
        // Done is still honoured TIMEOUT cycles after the pulse; the flag follows on the next
        check_eq("to_err_cycle", cyc, TIMEOUT + 1);
        check_eq("to_err_set", timeout_err, 1'b1);
        check_eq("to_busy_idle", busy, 1'b0);
        check_eq("to_no_rx", q_if.rx_valid, 1'b0);
        @(posedge clk); #1 resp_en = 1'b1;
        push_word(8'h66);
        for (int i = 0; i < 100 && rx_got.size() < 1; i++) @(negedge clk);
        check_eq("to_next_start", q_at(starts_q, 1), 8'h66);
        check_eq("to_next_rx", q_at(rx_got, 0), 8'h16);
        check_eq("to_err_sticky", timeout_err, 1'b1);

        // Done in the last allowed cycle wins over timeout
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst2");
        @(posedge clk); #1;
        rx_got.delete();
        resp_lat = TIMEOUT;
        push_word(8'h77);
        for (int i = 0; i < 200 && rx_got.size() < 1; i++) @(negedge clk);
        check_eq("simul_rx", q_at(rx_got, 0), 8'h66);
        check_eq("simul_no_err", timeout_err, 1'b0);

        // Reset mid-transfer, then a stray done
        @(posedge clk); #1;
        starts_q.delete();
        rx_got.delete();
        resp_en  = 1'b0;
        resp_lat = 5;
        push_word(8'h88);
        push_word(8'h89);
        for (int i = 0; i < 50 && starts_q.size() < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        q_if.spi_rx   = 8'h99;
        q_if.spi_done = 1'b1;
        @(posedge clk); #1 q_if.spi_done = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("midrst");
        check_eq("midrst_n_rx", rx_got.size(), 0);
        check_eq("midrst_n_starts", starts_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
